// File: rtl/mac_seq_pkg.sv
// Shared types and defaults for the MAC window sequencer and its tap counter.
package mac_seq_pkg;

  localparam int unsigned TAPS_DEF  = 9;
  localparam int unsigned RES_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    HOLD
  } seq_state_e;

  // Minimum address width able to index taps 0..taps-1.
  function automatic int unsigned tap_width(input int unsigned taps);
    return (taps <= 2) ? 1 : $clog2(taps);
  endfunction

endpackage

// File: rtl/tap_counter.sv
// Loadable, enable-gated tap address counter with a terminal flag at TAPS-1.
module tap_counter
  import mac_seq_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned TAP_W = tap_width(TAPS_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TAP_W-1:0] load_val,
  input  logic             en,
  output logic [TAP_W-1:0] count,
  output logic             term_c
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + TAP_W'(1);
    end
  end

  assign term_c = (count == TAP_W'(TAPS - 1));

endmodule

// File: rtl/mac_window_sequencer.sv
// Drives one convolution window through the accumulator (clear, TAPS accumulate
// steps, one drain cycle) and hands the captured sum out on a valid/ready port.
module mac_window_sequencer
  import mac_seq_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEF,
  parameter int unsigned RES_W = RES_W_DEF,
  parameter int unsigned TAP_W = tap_width(TAPS_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             abort,
  output logic [TAP_W-1:0] tap_addr,
  output logic             acc_clr,
  output logic             acc_en,
  input  logic [RES_W-1:0] acc_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic             busy,
  output logic [15:0]      win_count
);

  seq_state_e state;
  seq_state_e state_d;
  logic       cnt_load_c;
  logic       cnt_en_c;
  logic       cnt_term_c;

  tap_counter #(
    .TAPS  (TAPS),
    .TAP_W (TAP_W)
  ) u_tap_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val ('0),
    .en       (cnt_en_c),
    .count    (tap_addr),
    .term_c   (cnt_term_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and counter control; abort wins over every other transition.
  always_comb begin
    state_d    = state;
    cnt_load_c = 1'b0;
    cnt_en_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start_valid && !abort) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_load_c = 1'b1;
        state_d    = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_term_c) begin
          state_d = DRAIN;
        end else begin
          cnt_en_c = 1'b1;
        end
      end
      DRAIN: begin
        state_d = abort ? IDLE : HOLD;
      end
      HOLD: begin
        if (abort || res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control outputs are flops that track the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_ready <= 1'b1;
      acc_clr     <= 1'b0;
      acc_en      <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_ready <= (state_d == IDLE);
      acc_clr     <= (state_d == CLEAR);
      acc_en      <= (state_d == RUN);
      res_valid   <= (state_d == HOLD);
      busy        <= (state_d != IDLE);
    end
  end

  // Result capture at the end of DRAIN and completed-window count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data  <= '0;
      win_count <= '0;
    end else begin
      if ((state == DRAIN) && !abort) begin
        res_data <= acc_result;
      end
      if ((state == HOLD) && res_ready && !abort) begin
        win_count <= win_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mac_window_sequencer.sv
// Directed bench for mac_window_sequencer with an accumulator model and a
// result scoreboard filled at each accepted start.
module tb_mac_window_sequencer;

  localparam int unsigned TAPS  = 9;
  localparam int unsigned RES_W = 32;
  localparam int unsigned TAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic             abort = 1'b0;
  logic [TAP_W-1:0] tap_addr;
  logic             acc_clr;
  logic             acc_en;
  logic [RES_W-1:0] acc_result;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [RES_W-1:0] res_data;
  logic             busy;
  logic [15:0]      win_count;

  mac_window_sequencer #(
    .TAPS  (TAPS),
    .RES_W (RES_W),
    .TAP_W (TAP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .abort       (abort),
    .tap_addr    (tap_addr),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .acc_result  (acc_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .win_count   (win_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int rv_cyc = -100;
  int n_accepts = 0;
  logic prev_rv = 1'b0;
  logic [31:0] acc = 32'd0;
  logic [31:0] exp_q[$];

  // Mode 0: product = tap+1 (sum 45). Mode 1: 0xFFFFFFF0 + 0x20, wrapping.
  function automatic logic [31:0] prod(input logic [TAP_W-1:0] t);
    if (mode == 0) return 32'(t) + 32'd1;
    if (t == 4'd0) return 32'hFFFF_FFF0;
    if (t == 4'd1) return 32'h0000_0020;
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (acc_clr) acc <= 32'd0;
    else if (acc_en) acc <= acc + prod(tap_addr);
  end
  assign acc_result = acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict acceptance, advance to the falling edge, score results.
  task automatic tick();
    logic will_acc;
    will_acc = start_ready && start_valid && !abort && !reset;
    @(negedge clk);
    cyc++;
    if (will_acc) begin
      exp_q.push_back((mode == 0) ? 32'd45 : 32'h0000_0010);
      acc_cyc = cyc - 1;
      n_accepts++;
    end
    if (res_valid && !prev_rv) begin
      rv_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_result", 64'(exp_q.size()), 64'd1);
      else chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
    prev_rv = res_valid;
  endtask

  task automatic start_one(input int m);
    mode = m;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_for_rv(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rv_seen"}, 64'(res_valid), 64'd1);
  endtask

  initial begin
    int n, first, a1, a2;

    // Reset values while reset is held.
    #1;
    chk("rst_tap_addr", 64'(tap_addr), 64'd0);
    chk("rst_acc_clr", 64'(acc_clr), 64'd0);
    chk("rst_acc_en", 64'(acc_en), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_win_count", 64'(win_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("start_ready_after_reset", 64'(start_ready), 64'd1);

    // Single window, cycle by cycle.
    start_one(0);
    chk("clr_cycle_acc_clr", 64'(acc_clr), 64'd1);
    chk("clr_cycle_acc_en", 64'(acc_en), 64'd0);
    chk("clr_cycle_busy", 64'(busy), 64'd1);
    chk("clr_cycle_start_ready", 64'(start_ready), 64'd0);
    for (int k = 0; k < int'(TAPS); k++) begin
      tick();
      chk("run_acc_en", 64'(acc_en), 64'd1);
      chk("run_acc_clr", 64'(acc_clr), 64'd0);
      chk("run_tap_addr", 64'(tap_addr), 64'(k));
    end
    tick();
    chk("drain_acc_en", 64'(acc_en), 64'd0);
    chk("drain_tap_addr", 64'(tap_addr), 64'(TAPS - 1));
    chk("drain_res_valid", 64'(res_valid), 64'd0);
    tick();
    chk("hold_res_valid", 64'(res_valid), 64'd1);
    chk("latency", 64'(rv_cyc - acc_cyc), 64'(TAPS + 3));
    res_ready = 1'b1;
    tick();
    chk("post_hs_res_valid", 64'(res_valid), 64'd0);
    chk("post_hs_win_count", 64'(win_count), 64'd1);
    chk("post_hs_start_ready", 64'(start_ready), 64'd1);

    // Back-to-back starts with res_ready held high.
    mode = 0;
    first = n_accepts;
    a1 = -1;
    a2 = -1;
    start_valid = 1'b1;
    n = 0;
    while (n_accepts < first + 2 && n < 60) begin
      tick();
      if (n_accepts == first + 1 && a1 < 0) a1 = acc_cyc;
      if (n_accepts == first + 2) a2 = acc_cyc;
      n++;
    end
    start_valid = 1'b0;
    chk("b2b_spacing", 64'(a2 - a1), 64'(TAPS + 4));
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("b2b_accepts", 64'(n_accepts - first), 64'd2);
    chk("b2b_win_count", 64'(win_count), 64'd3);

    // Backpressure: result held for 20 cycles.
    res_ready = 1'b0;
    start_one(0);
    wait_for_rv("bp");
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      chk("bp_res_data", 64'(res_data), 64'd45);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_res_valid", 64'(res_valid), 64'd0);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_start_ready", 64'(start_ready), 64'd1);
    chk("bp_win_count", 64'(win_count), 64'd4);

    // Abort in RUN at tap 4.
    start_one(0);
    n = 0;
    while (!(acc_en && tap_addr == 4'd4) && n < 20) begin
      tick();
      n++;
    end
    chk("abort_at_tap4", 64'(tap_addr), 64'd4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_acc_en", 64'(acc_en), 64'd0);
    chk("abort_acc_clr", 64'(acc_clr), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_win_count", 64'(win_count), 64'd4);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (15) tick();
    chk("abort_no_result", 64'(res_valid), 64'd0);

    // Abort in IDLE blocks acceptance.
    start_valid = 1'b1;
    abort = 1'b1;
    tick();
    tick();
    chk("abort_idle_block", 64'(busy), 64'd0);
    start_valid = 1'b0;
    abort = 1'b0;

    // Window after abort sums from a cleared accumulator.
    res_ready = 1'b1;
    start_one(0);
    wait_for_rv("post_abort");
    tick();
    chk("post_abort_win_count", 64'(win_count), 64'd5);

    // Asynchronous reset during DRAIN.
    res_ready = 1'b0;
    start_one(0);
    n = 0;
    while (!(busy && !acc_en && !acc_clr && !res_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_reached_tap", 64'(tap_addr), 64'(TAPS - 1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_tap_addr", 64'(tap_addr), 64'd0);
    chk("arst_acc_en", 64'(acc_en), 64'd0);
    chk("arst_acc_clr", 64'(acc_clr), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_res_data", 64'(res_data), 64'd0);
    chk("arst_win_count", 64'(win_count), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prev_rv = 1'b0;
    res_ready = 1'b1;
    start_one(0);
    wait_for_rv("post_reset");
    tick();
    chk("post_reset_win_count", 64'(win_count), 64'd1);

    // Accumulator overflow passes through unchanged.
    start_one(1);
    wait_for_rv("overflow");
    tick();
    chk("overflow_win_count", 64'(win_count), 64'd2);
    chk("overflow_res_data_held", 64'(res_data), 64'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
